// File: rtl/ttt_pkg.sv
// Shared types and encodings for the tic-tac-toe move/judge pipeline.
package ttt_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    JREQ  = 3'd2,
    JWAIT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;

  localparam logic PLAYER_A = 1'b0;
  localparam logic PLAYER_B = 1'b1;

  // A wins any both-winners protocol error; no winner unless the game ended.
  function automatic logic [1:0] encode_winner(input logic game_end,
                                               input logic win_a,
                                               input logic win_b);
    if (!game_end)  return WIN_NONE;
    else if (win_a) return WIN_A;
    else if (win_b) return WIN_B;
    else            return WIN_NONE;
  endfunction

endpackage

// File: rtl/move_applier.sv
// Applies moves to the occupancy boards, handshakes with the judge and holds the result.
// Optional MOVE_APPLIER_ILLEGAL_CNT_EN adds a saturating illegal-move counter output.
//
// state | meaning
// IDLE  | ready for a move (move_ready=1 unless game over)
// CHECK | validate latched cell, update board/turn/count if legal
// JREQ  | wait for judge_ready, then raise a one-cycle judge_req
// JWAIT | wait for judge_valid, capture result
// OVER  | game finished, moves ignored until new_game
module move_applier
  import ttt_pkg::*;
#(
  parameter int ROWS  = 3,
  parameter int COLS  = 3,
  parameter int CELLS = ROWS * COLS,
  parameter int POS_W = $clog2(CELLS),
  parameter int CNT_W = $clog2(CELLS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_game,
  input  logic             move_valid,
  input  logic [POS_W-1:0] move_pos,
  output logic             move_ready,
  output logic             illegal_move,
  output logic [CELLS-1:0] board_a,
  output logic [CELLS-1:0] board_b,
  output logic             turn,
  output logic [CNT_W-1:0] move_count,
  output logic             judge_req,
  input  logic             judge_ready,
  input  logic             judge_valid,
  input  logic             judge_end,
  input  logic             judge_win_a,
  input  logic             judge_win_b,
  output logic             game_over,
  output logic [1:0]       winner,
`ifdef MOVE_APPLIER_ILLEGAL_CNT_EN
  output logic [7:0]       illegal_count,
`endif
  output logic             result_valid
);

  localparam logic [POS_W:0] CELLS_LIM = (POS_W + 1)'(CELLS);

  state_t           state, state_d;
  logic [POS_W-1:0] pos_q;
  logic [CELLS-1:0] pos_mask;
  logic             legal;
  logic             accept;

  // Shift-based mask reads as zero for any index past the board.
  assign pos_mask = CELLS'(1) << pos_q;
  assign legal    = ({1'b0, pos_q} < CELLS_LIM) && ((pos_mask & (board_a | board_b)) == '0);
  assign accept   = move_valid && move_ready;

  always_comb begin
    state_d = state;
    if (new_game) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_d = CHECK;
        CHECK:   state_d = legal ? JREQ : IDLE;
        JREQ:    if (judge_ready && !judge_req) state_d = JWAIT;
        JWAIT:   if (judge_valid) state_d = judge_end ? OVER : IDLE;
        OVER:    state_d = OVER;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_ready   <= 1'b0;
      illegal_move <= 1'b0;
      board_a      <= '0;
      board_b      <= '0;
      turn         <= PLAYER_A;
      move_count   <= '0;
      judge_req    <= 1'b0;
      game_over    <= 1'b0;
      winner       <= WIN_NONE;
      result_valid <= 1'b0;
      pos_q        <= '0;
    end else begin
      illegal_move <= 1'b0;
      result_valid <= 1'b0;
      judge_req    <= 1'b0;
      // Every path into IDLE has game_over clear, so this covers the ready rule.
      move_ready   <= (state_d == IDLE);
      if (new_game) begin
        board_a    <= '0;
        board_b    <= '0;
        turn       <= PLAYER_A;
        move_count <= '0;
        game_over  <= 1'b0;
        winner     <= WIN_NONE;
      end else begin
        case (state)
          IDLE: if (accept) pos_q <= move_pos;
          CHECK: begin
            if (legal) begin
              if (turn == PLAYER_A) board_a <= board_a | pos_mask;
              else                  board_b <= board_b | pos_mask;
              turn       <= (turn == PLAYER_A) ? PLAYER_B : PLAYER_A;
              move_count <= move_count + CNT_W'(1);
            end else begin
              illegal_move <= 1'b1;
            end
          end
          JREQ: if (judge_ready && !judge_req) judge_req <= 1'b1;
          JWAIT: begin
            if (judge_valid) begin
              game_over    <= judge_end;
              winner       <= encode_winner(judge_end, judge_win_a, judge_win_b);
              result_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MOVE_APPLIER_ILLEGAL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     illegal_count <= 8'd0;
    else if (new_game)                             illegal_count <= 8'd0;
    else if (illegal_move && illegal_count != 8'hFF) illegal_count <= illegal_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_move_applier.sv
// Directed self-checking bench for move_applier (3x3 board).
module tb_move_applier;

  localparam int CELLS = 9;
  localparam int POS_W = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             new_game = 1'b0;
  logic             move_valid = 1'b0;
  logic [POS_W-1:0] move_pos = '0;
  logic             move_ready;
  logic             illegal_move;
  logic [CELLS-1:0] board_a;
  logic [CELLS-1:0] board_b;
  logic             turn;
  logic [CNT_W-1:0] move_count;
  logic             judge_req;
  logic             judge_ready = 1'b1;
  logic             judge_valid = 1'b0;
  logic             judge_end = 1'b0;
  logic             judge_win_a = 1'b0;
  logic             judge_win_b = 1'b0;
  logic             game_over;
  logic [1:0]       winner;
  logic             result_valid;
`ifdef MOVE_APPLIER_ILLEGAL_CNT_EN
  logic [7:0]       illegal_count;
`endif

  int tests = 0;
  int fails = 0;
  int req_cnt = 0;
  int r0;

  move_applier #(.ROWS(3), .COLS(3)) dut (
    .clk(clk), .reset(reset), .new_game(new_game),
    .move_valid(move_valid), .move_pos(move_pos), .move_ready(move_ready),
    .illegal_move(illegal_move), .board_a(board_a), .board_b(board_b),
    .turn(turn), .move_count(move_count), .judge_req(judge_req),
    .judge_ready(judge_ready), .judge_valid(judge_valid), .judge_end(judge_end),
    .judge_win_a(judge_win_a), .judge_win_b(judge_win_b),
    .game_over(game_over), .winner(winner),
`ifdef MOVE_APPLIER_ILLEGAL_CNT_EN
    .illegal_count(illegal_count),
`endif
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (judge_req) req_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
  endtask

  task automatic send_move(input logic [POS_W-1:0] pos);
    int n = 0;
    while (!move_ready && n < 10) begin
      step();
      n++;
    end
    if (!move_ready) check("ready_timeout", 0, 1);
    move_valid = 1'b1;
    move_pos   = pos;
    step();
    move_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!judge_req && n < 20) begin
      step();
      n++;
    end
    if (!judge_req) check("req_timeout", 0, 1);
  endtask

  task automatic judge_reply(input logic e, input logic a, input logic b);
    judge_valid = 1'b1;
    judge_end   = e;
    judge_win_a = a;
    judge_win_b = b;
    step();
    judge_valid = 1'b0;
    judge_end   = 1'b0;
    judge_win_a = 1'b0;
    judge_win_b = 1'b0;
  endtask

  task automatic play(input logic [POS_W-1:0] pos, input logic e, input logic a, input logic b);
    send_move(pos);
    wait_req();
    judge_reply(e, a, b);
  endtask

  initial begin
    #3;
    check("rst_ready", move_ready, 0);
    check("rst_board_a", board_a, 0);
    check("rst_turn", turn, 0);
    check("rst_req", judge_req, 0);
    check("rst_over", game_over, 0);
    reset = 1'b0;
    step();

    // first move, one judge handshake, game continues
    send_move(4'd4);
    step();
    check("t1_board_a", board_a, 9'h010);
    check("t1_turn", turn, 1);
    check("t1_count", move_count, 1);
    check("t1_req_early", judge_req, 0);
    wait_req();
    judge_reply(1'b0, 1'b0, 1'b0);
    check("t1_result_valid", result_valid, 1);
    check("t1_over", game_over, 0);
    check("t1_req_low", judge_req, 0);
    step();
    check("t1_result_pulse", result_valid, 0);
    check("t1_req_cnt", req_cnt, 1);
    check("t1_ready_again", move_ready, 1);

    // A wins along the top row
    start_game();
    play(4'd0, 0, 0, 0);
    play(4'd3, 0, 0, 0);
    play(4'd1, 0, 0, 0);
    play(4'd4, 0, 0, 0);
    play(4'd2, 1, 1, 0);
    check("t2_over", game_over, 1);
    check("t2_winner", winner, 2'b01);
    check("t2_board_a", board_a, 9'h007);
    check("t2_board_b", board_b, 9'h018);
    check("t2_count", move_count, 5);
    check("t2_ready", move_ready, 0);
    move_valid = 1'b1;
    move_pos   = 4'd8;
    repeat (3) step();
    move_valid = 1'b0;
    check("t2_ignored_b", board_b, 9'h018);
    check("t2_ignored_cnt", move_count, 5);
    check("t2_ready_held", move_ready, 0);

    // occupied cell is illegal
    start_game();
    play(4'd4, 0, 0, 0);
    step();
    r0 = req_cnt;
    send_move(4'd4);
    step();
    check("t3_illegal", illegal_move, 1);
    check("t3_board_b", board_b, 0);
    check("t3_turn", turn, 1);
    check("t3_count", move_count, 1);
    step();
    check("t3_illegal_pulse", illegal_move, 0);
    repeat (3) step();
    check("t3_no_req", req_cnt, r0);
`ifdef MOVE_APPLIER_ILLEGAL_CNT_EN
    check("t3_ill_cnt", illegal_count, 1);
`endif

    // off-board index is illegal, then a both-winners verdict goes to A
    send_move(4'd9);
    step();
    check("t4_illegal", illegal_move, 1);
    check("t4_board_a", board_a, 9'h010);
    check("t4_count", move_count, 1);
`ifdef MOVE_APPLIER_ILLEGAL_CNT_EN
    step();
    check("t4_ill_cnt", illegal_count, 2);
`endif
    play(4'd5, 1, 1, 1);
    check("t4_board_b", board_b, 9'h020);
    check("t4_both_win", winner, 2'b01);
    check("t4_over", game_over, 1);

    // new_game during JWAIT abandons the judgement
    start_game();
`ifdef MOVE_APPLIER_ILLEGAL_CNT_EN
    check("t5_ill_cnt_clr", illegal_count, 0);
`endif
    send_move(4'd0);
    wait_req();
    step();
    start_game();
    check("t5_board_a", board_a, 0);
    check("t5_turn", turn, 0);
    check("t5_count", move_count, 0);
    check("t5_ready", move_ready, 1);
    judge_reply(1'b1, 1'b1, 1'b0);
    check("t5_late_valid", result_valid, 0);
    check("t5_late_over", game_over, 0);

    // judge busy holds off the request; board stays put
    start_game();
    judge_ready = 1'b0;
    send_move(4'd2);
    step();
    r0 = req_cnt;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t6_req_held", judge_req, 0);
      check("t6_board_stable", board_a, 9'h004);
    end
    judge_ready = 1'b1;
    step();
    check("t6_req_rise", judge_req, 1);
    check("t6_board_at_req", board_a, 9'h004);
    step();
    check("t6_req_one_cycle", judge_req, 0);
    check("t6_board_wait", board_a, 9'h004);
    judge_reply(1'b0, 1'b0, 1'b0);
    check("t6_result", result_valid, 1);
    check("t6_req_cnt", req_cnt - r0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/move_applier.md
Name: move_applier

Overview:
- Stage directly upstream of the game judge.
- Accepts one move (cell index) at a time for the side to play, rejects illegal moves, and updates the two occupancy boards.
- After each legal move, handshakes with the judge, then publishes the game result.
- Owns turn order and move count for one game of ROWS x COLS tic-tac-toe.

Parameters:
- ROWS, 3, board rows.
- COLS, 3, board columns. CELLS = ROWS*COLS; POS_W = $clog2(CELLS).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- new_game  in  1  synchronous clear of the game; level-sampled each cycle
- move_valid  in  1  move offered
- move_pos  in  POS_W  cell index, row-major, 0..CELLS-1
- move_ready  out  1  move accepted when move_valid && move_ready
- illegal_move  out  1  one-cycle pulse: last accepted move was rejected
- board_a  out  CELLS  player A occupancy, to judge
- board_b  out  CELLS  player B occupancy, to judge
- turn  out  1  0 = A to move, 1 = B to move
- move_count  out  $clog2(CELLS+1)  legal moves applied this game
- judge_req  out  1  request to judge (registered)
- judge_ready  in  1  judge idle and able to take req
- judge_valid  in  1  judge result strobe
- judge_end  in  1  judge end_of_game
- judge_win_a  in  1  judge win_a
- judge_win_b  in  1  judge win_b
- game_over  out  1  game finished; held until new_game
- winner  out  2  00 none/draw, 01 A, 10 B; valid while game_over
- result_valid  out  1  one-cycle pulse per completed judgement

Behaviour:
- Reset values, all outputs 0. State is IDLE, turn=A, move_ready=0.
- move_ready is registered and is 1 only in IDLE with game_over=0.
- States:
  - IDLE: on accept, latch move_pos, clear move_ready, go CHECK.
  - CHECK: if pos >= CELLS or board_a[pos]|board_b[pos], pulse illegal_move and return to IDLE. Board, turn and count are unchanged.
  - CHECK, legal move: set the mover's bit, toggle turn, increment move_count, go JREQ.
  - JREQ: when judge_ready=1 and judge_req=0, drive judge_req<=1 and go JWAIT.
  - JWAIT: judge_req<=0 next cycle, so req is exactly one cycle wide. Wait for judge_valid.
  - On judge_valid: capture judge_end/judge_win_a/judge_win_b into game_over/winner, pulse result_valid.
  - After judge_valid: if game_over go OVER, else go IDLE.
  - OVER: move_ready=0; move_valid is ignored.
- Latency: move accepted at edge N; boards update at edge N+1. judge_req rises no earlier than edge N+2. result_valid fires one cycle after judge_valid.
- board_a/board_b change only in CHECK and stay stable from judge_req until judge_valid.
- judge_valid outside JWAIT is ignored.
- judge_win_a and judge_win_b both 1 is a protocol error; winner takes A.
- new_game overrides everything, in any state:
  - boards, turn, move_count, game_over and winner cleared; state goes to IDLE.
  - A judgement in flight is abandoned, and its later judge_valid is ignored.
  - Any handshaking move_valid in the same cycle is dropped.
- Reset mid-operation returns everything to reset values immediately (asynchronous).
- A move_pos index outside the board is illegal, not wrapped.
- A full board without a win is a draw: game_over=1, winner=00.

Optional Feature:
- Macro: MOVE_APPLIER_ILLEGAL_CNT_EN.
- Defined: extra output illegal_count [7:0]. It increments on each illegal_move pulse, saturates at 255, and is cleared by reset and by new_game.
- Not defined: the port is absent and no counter logic is built.

Decomposition:
- Package ttt_pkg holds:
  - state enum {IDLE, CHECK, JREQ, JWAIT, OVER}
  - winner encoding constants WIN_NONE=2'b00, WIN_A=2'b01, WIN_B=2'b10
  - player constants PLAYER_A=0, PLAYER_B=1
- No sub-module. Judge handshake and board update stay in one always_ff.

Test Plan:
- Reset, then move 4 → board_a=9'h010, turn=1, move_count=1. Exactly one judge_req pulse; judge_valid with end=0 → result_valid, game_over=0.
- A takes 0, B takes 3, A takes 1, B takes 4, A takes 2; judge returns win_a on the fifth move → game_over=1, winner=01. move_ready stays 0 and further moves are ignored.
- Move 4, then move 4 again → illegal_move pulse. board_b=0, turn=1, move_count=1, no judge_req.
- move_pos=9 → illegal_move pulse, no state change.
- Move, then new_game asserted during JWAIT → boards 0, turn 0, state IDLE. A late judge_valid is ignored (result_valid stays 0).
- Hold judge_ready=0 for 5 cycles in JREQ → judge_req stays 0. It pulses one cycle after judge_ready rises, and boards are stable throughout.
